fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the second fetch stage and decode.
- Captures each non-bubble fetch result (pc, instruction word, exception code) into a small circular FIFO.
- Presents the oldest entry to decode, which decouples the 2-cycle fetch pipe from decode stalls.
- Generates the fetch-side stall early enough to absorb the two fetches already in flight.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 4.
- SKID, 2, free entries reserved for in-flight fetches; stall_fetch asserts when free entries <= SKID.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (branch/interrupt redirect).
- bubble_in  in  1  fetch_b slot is empty; no enqueue this cycle.
- pc_in  in  32  pc of incoming slot.
- instr_in  in  32  instruction word returned by memory for pc_in.
- exc_in  in  8  exception code for the slot; 0 means none.
- stall_in  in  1  decode cannot accept this cycle.
- stall_fetch  out  1  hold both fetch stages.
- valid_out  out  1  head entry valid; inverse is the bubble to decode.
- pc_out  out  32  head pc.
- instr_out  out  32  head instruction.
- exc_out  out  8  head exception code.
- count_out  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0.
  - valid_out=0, stall_fetch=0, overflow=0.
  - pc_out, instr_out and exc_out drive 0 while empty.
  - Reset asserted mid-operation discards all entries immediately.
- Storage: DEPTH-entry array of {pc, instr, exc} = 72 bits. Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. count is tracked separately.
- Enqueue condition: enq = !bubble_in && !flush && (count < DEPTH || deq).
  - On enq, the entry is written at wr_ptr and wr_ptr increments.
- Dequeue condition: deq = valid_out && !stall_in && !flush.
  - On deq, rd_ptr increments.
- Head outputs are read combinationally from the array at rd_ptr; valid_out = (count != 0). There is no same-cycle bypass.
- Latency: a slot enqueued at edge N is visible on the head outputs during cycle N+1 if the queue was empty.
- Count update: count_next = count + enq - deq.
  - Simultaneous enq and deq when full is legal; count stays at DEPTH.
  - Simultaneous enq and deq when empty: the entry is enqueued and nothing is dequeued, because valid_out=0.
- Flush priority: flush outranks everything.
  - On a flush edge, count=0 and rd_ptr=wr_ptr=0.
  - The incoming slot is dropped even if it is not a bubble.
  - valid_out is 0 in the following cycle.
- stall_fetch = (DEPTH - count) <= SKID, combinational from registered count.
  - It does not depend on stall_in, so there is no combinational path from decode to fetch.
  - With DEPTH=4 and SKID=2, it asserts at count >= 2.
- Overflow:
  - Raised when !bubble_in && !flush && count==DEPTH && !deq; the incoming slot is discarded.
  - Set on that edge and held until reset; flush does not clear it.
- Exceptions are data only. exc_in is carried unchanged, and an entry with nonzero exc still carries pc and instr.
- No combinational path from any input to valid_out/pc_out/instr_out/exc_out.

Decomposition:
- Shared package:
  - FETCH_ENTRY_W = 72.
  - EXC_NONE = 8'h00.
  - Entry field offsets: pc [71:40], instr [39:8], exc [7:0].
- Natural sub-module: fetch_queue_ram, the DEPTH x 72 register array.
  - One write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Not reset.
- Pointer, count, flush and stall logic stay in fetch_queue.

Test Plan:
- Reset and fill:
  - Stimulus: rst_n low then high; three non-bubble slots pc=0x400/0x404/0x408, instr=0x11/0x22/0x33, stall_in=1.
  - Required: count_out=3; stall_fetch high from the cycle count reaches 2; head pc_out=0x400, instr_out=0x11; overflow=0.
- Drain order:
  - Stimulus: from the filled state, release stall_in for three cycles with bubble_in=1.
  - Required: valid_out=1 with pc_out 0x400, 0x404, 0x408 in consecutive cycles, then valid_out=0, count_out=0.
- Full with simultaneous enq/deq:
  - Stimulus: fill to 4, then one cycle with pc_in=0x410 and stall_in=0.
  - Required: count stays 4; the head advances to the second entry; 0x410 becomes the tail.
- Overflow:
  - Stimulus: at count=4, stall_in=1, non-bubble slot pc=0x500.
  - Required: overflow=1 sticky; count=4; 0x500 is never presented on pc_out.
- Flush:
  - Stimulus: count=3, flush=1 together with non-bubble pc=0x600.
  - Required: next cycle valid_out=0, count=0, stall_fetch=0; the next enqueued pc=0x800 appears as head one cycle after its enqueue.
- Async reset mid-stream:
  - Stimulus: pull rst_n low between clock edges at count=2.
  - Required: valid_out, count_out and stall_fetch go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
package fetch_queue_pkg;

  localparam int FETCH_ENTRY_W = 72;

  localparam logic [7:0] EXC_NONE = 8'h00;

  // Field offsets inside a packed entry.
  localparam int PC_LSB    = 40;
  localparam int INSTR_LSB = 8;
  localparam int EXC_LSB   = 0;

  // Packed layout matches the offsets above: pc [71:40], instr [39:8], exc [7:0].
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_queue_pkg::*;

  // Fetch side
  logic        flush;
  logic        bubble_in;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic [7:0]  exc_in;
  logic        stall_fetch;

  // Decode side
  logic        stall_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [7:0]  exc_out;

  // Status
  logic [$clog2(DEPTH):0] count_out;
  logic                   overflow;

  // The queue itself
  modport slave (
    input  flush, bubble_in, pc_in, instr_in, exc_in, stall_in,
    output stall_fetch, valid_out, pc_out, instr_out, exc_out, count_out, overflow
  );

  // Whoever drives fetch results and decode stalls
  modport master (
    output flush, bubble_in, pc_in, instr_in, exc_in, stall_in,
    input  stall_fetch, valid_out, pc_out, instr_out, exc_out, count_out, overflow
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x 72 entry storage: one synchronous write port, one asynchronous read port.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the incoming entry at the tail slot.
  // NOTE: storage has no reset; occupancy is tracked by the pointers/count, and
  // the head outputs are masked while empty, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch stage 2 and decode. Stalls fetch
// early enough that the two fetches already in flight always find room.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - SKID);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             valid;
  logic             enq;
  logic             deq;
  logic             ovf_hit;
  fetch_entry_t     wdata;
  fetch_entry_t     head;

  assign valid = (count != '0);

  // Decode only consumes a valid head; flush overrides both directions.
  assign deq     = valid && !bus.stall_in && !bus.flush;
  assign enq     = !bus.bubble_in && !bus.flush && ((count < CNT_FULL) || deq);
  assign ovf_hit = !bus.bubble_in && !bus.flush && (count == CNT_FULL) && !deq;

  assign wdata = '{pc: bus.pc_in, instr: bus.instr_in, exc: bus.exc_in};

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer, occupancy and sticky overflow state.
  // NOTE: every register here uses <= so all of them sample pre-edge values,
  // which keeps enq/deq and count consistent within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
      if (ovf_hit) overflow_q <= 1'b1;
    end
  end

  // Head outputs read straight from storage, forced to zero while empty.
  // NOTE: outputs get defaults first so no path through this block infers a latch.
  always_comb begin
    bus.pc_out    = '0;
    bus.instr_out = '0;
    bus.exc_out   = EXC_NONE;
    if (valid) begin
      bus.pc_out    = head.pc;
      bus.instr_out = head.instr;
      bus.exc_out   = head.exc;
    end
  end

  // Registered count only, so decode stall never reaches fetch combinationally.
  assign bus.stall_fetch = (count >= CNT_STALL);
  assign bus.valid_out   = valid;
  assign bus.count_out   = count;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, SKID=2).
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4), .SKID(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [31:0] pc, input logic [31:0] instr, input logic [7:0] exc);
    bus.bubble_in = 1'b0;
    bus.pc_in     = pc;
    bus.instr_in  = instr;
    bus.exc_in    = exc;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [2:0] cnt);
    check({tag, "_valid"}, bus.valid_out, 1);
    check({tag, "_pc"},    bus.pc_out,    pc);
    check({tag, "_instr"}, bus.instr_out, instr);
    check({tag, "_count"}, bus.count_out, cnt);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.bubble_in = 1'b1;
    bus.pc_in     = '0;
    bus.instr_in  = '0;
    bus.exc_in    = EXC_NONE;
    bus.stall_in  = 1'b1;

    // Reset state
    #12;
    check("rst_valid",    bus.valid_out,   0);
    check("rst_count",    bus.count_out,   0);
    check("rst_stall",    bus.stall_fetch, 0);
    check("rst_overflow", bus.overflow,    0);
    check("rst_pc",       bus.pc_out,      0);
    rst_n = 1'b1;
    tick();

    // Fill three entries with decode stalled
    slot(32'h400, 32'h11, 8'h00); tick();
    check_head("fill1", 32'h400, 32'h11, 1);
    check("fill1_stall", bus.stall_fetch, 0);
    slot(32'h404, 32'h22, 8'h05); tick();
    check("fill2_count", bus.count_out, 2);
    check("fill2_stall", bus.stall_fetch, 1);
    slot(32'h408, 32'h33, 8'h00); tick();
    check_head("fill3", 32'h400, 32'h11, 3);
    check("fill3_stall", bus.stall_fetch, 1);
    check("fill3_overflow", bus.overflow, 0);

    // Drain in order
    bus.bubble_in = 1'b1;
    bus.stall_in  = 1'b0;
    tick();
    check_head("drain1", 32'h404, 32'h22, 2);
    check("drain1_exc", bus.exc_out, 8'h05);
    tick();
    check_head("drain2", 32'h408, 32'h33, 1);
    check("drain2_exc", bus.exc_out, 8'h00);
    tick();
    check("drain3_valid", bus.valid_out, 0);
    check("drain3_count", bus.count_out, 0);
    check("drain3_pc",    bus.pc_out,    0);
    check("drain3_stall", bus.stall_fetch, 0);

    // Enqueue into empty queue with decode ready: no dequeue that cycle
    slot(32'h700, 32'hA0, 8'h00); tick();
    check_head("empty_enq", 32'h700, 32'hA0, 1);
    bus.stall_in = 1'b1;
    slot(32'h704, 32'hA1, 8'h00); tick();
    slot(32'h708, 32'hA2, 8'h00); tick();
    slot(32'h70C, 32'hA3, 8'h00); tick();
    check_head("full", 32'h700, 32'hA0, 4);
    check("full_stall", bus.stall_fetch, 1);

    // Simultaneous enq/deq while full
    bus.stall_in = 1'b0;
    slot(32'h410, 32'h44, 8'h00); tick();
    check_head("full_enqdeq", 32'h704, 32'hA1, 4);
    check("full_enqdeq_ovf", bus.overflow, 0);

    // Overflow: full, stalled, non-bubble slot is discarded
    bus.stall_in = 1'b1;
    slot(32'h500, 32'h55, 8'h00); tick();
    check("ovf_flag", bus.overflow, 1);
    check_head("ovf", 32'h704, 32'hA1, 4);

    // Drain: 0x410 is the tail and 0x500 never appears
    bus.bubble_in = 1'b1;
    bus.stall_in  = 1'b0;
    tick(); check_head("post_ovf1", 32'h708, 32'hA2, 3);
    tick(); check_head("post_ovf2", 32'h70C, 32'hA3, 2);
    tick(); check_head("post_ovf3", 32'h410, 32'h44, 1);
    tick();
    check("post_ovf4_valid", bus.valid_out, 0);
    check("ovf_sticky", bus.overflow, 1);

    // Flush drops everything, including the incoming slot
    bus.stall_in = 1'b1;
    slot(32'h900, 32'hB0, 8'h00); tick();
    slot(32'h904, 32'hB1, 8'h00); tick();
    slot(32'h908, 32'hB2, 8'h00); tick();
    check("pre_flush_count", bus.count_out, 3);
    bus.flush = 1'b1;
    slot(32'h600, 32'h66, 8'h00); tick();
    check("flush_valid", bus.valid_out, 0);
    check("flush_count", bus.count_out, 0);
    check("flush_stall", bus.stall_fetch, 0);
    check("flush_ovf_kept", bus.overflow, 1);
    bus.flush = 1'b0;
    slot(32'h800, 32'h88, 8'h07); tick();
    check_head("post_flush", 32'h800, 32'h88, 1);
    check("post_flush_exc", bus.exc_out, 8'h07);

    // Async reset between edges at count=2
    slot(32'h804, 32'h89, 8'h00); tick();
    check("pre_rst_count", bus.count_out, 2);
    check("pre_rst_stall", bus.stall_fetch, 1);
    bus.bubble_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.valid_out,   0);
    check("arst_count", bus.count_out,   0);
    check("arst_stall", bus.stall_fetch, 0);
    check("arst_ovf",   bus.overflow,    0);
    #3;
    rst_n = 1'b1;
    tick();
    check("arst_hold_valid", bus.valid_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
